// File: rtl/pixel_pack_writer_pkg.sv
// rtl/pixel_pack_writer_pkg.sv - shared lane geometry, state encoding and lane-mask helper
package pixel_pack_writer_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 8;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Byte enables for lanes 0..lane inclusive.
  function automatic logic [LANES-1:0] fill_mask(input logic [2:0] lane);
    return 8'hFF >> (3'd7 - lane);
  endfunction

endpackage

// File: rtl/pixel_pack_writer.sv
// rtl/pixel_pack_writer.sv - packs 8-bit pixels into 64-bit byte-enabled frame buffer writes
module pixel_pack_writer
  import pixel_pack_writer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int FRAME_PIXELS = 2400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [LANE_W-1:0]     pix_data,
  input  logic                  pix_last,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_W-1:0]     ram_data,
  output logic [LANES-1:0]      ram_be,
  output logic                  ram_we,
  output logic                  frame_done,
  output logic                  err
);

  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_PIXELS - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WORD_W-1:0]     acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0]     ram_data_q, ram_data_d;
  logic [LANES-1:0]      ram_be_q, ram_be_d;
  logic                  ram_we_q, ram_we_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [2:0]            lane;
  logic [WORD_W-1:0]     merged;
  logic                  at_limit;
  logic                  is_final;
  logic                  word_done;

  assign accept    = pix_valid && (state_q == ACTIVE);
  assign lane      = count_q[2:0];
  assign merged    = acc_q | (WORD_W'(pix_data) << {lane, 3'b000});
  assign at_limit  = (count_q == LAST_CNT);
  assign is_final  = accept && (pix_last || at_limit);
  assign word_done = accept && ((lane == 3'd7) || pix_last || at_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = ACTIVE;
      ACTIVE:  if (is_final) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == ACTIVE);
  end

  // Datapath: accumulator merges each accepted byte; a completed word is
  // copied to the output register in the same edge so the accumulator is free.
  always_comb begin
    count_d      = count_q;
    acc_d        = acc_q;
    addr_d       = addr_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_be_d     = ram_be_q;
    ram_we_d     = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;

    if ((state_q == IDLE) && start) begin
      count_d = '0;
      acc_d   = '0;
      addr_d  = '0;
      err_d   = 1'b0;
    end

    if (accept) begin
      count_d = count_q + CW'(1);
      acc_d   = merged;
      // Early pix_last and a missing pix_last at the limit are both errors.
      if (pix_last != at_limit) err_d = 1'b1;
      if (word_done) begin
        ram_we_d     = 1'b1;
        ram_addr_d   = addr_q;
        ram_data_d   = merged;
        ram_be_d     = fill_mask(lane);
        frame_done_d = is_final;
        acc_d        = '0;
        addr_d       = addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      acc_q        <= '0;
      addr_q       <= '0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_be_q     <= '0;
      ram_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      acc_q        <= acc_d;
      addr_q       <= addr_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_be_q     <= ram_be_d;
      ram_we_q     <= ram_we_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_be     = ram_be_q;
  assign ram_we     = ram_we_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pixel_pack_writer.sv
// tb/tb_pixel_pack_writer.sv - table-driven self-checking bench for pixel_pack_writer
module tb_pixel_pack_writer;

  localparam int AW = 10;
  localparam int FP = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          pix_last;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_data;
  logic [7:0]    ram_be;
  logic          ram_we;
  logic          frame_done;
  logic          err;

  pixel_pack_writer #(.ADDR_WIDTH(AW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_be(ram_be), .ram_we(ram_we),
    .frame_done(frame_done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          n;
    bit          use_last;
    bit          gappy;
    int          nw;
    int          a0;
    logic [63:0] d0;
    logic [7:0]  b0;
    int          a1;
    logic [63:0] d1;
    logic [7:0]  b1;
    bit          exp_err;
  } vec_t;

  vec_t vec[8];

  int compared   = 0;
  int mismatched = 0;

  logic [AW-1:0] wa[4];
  logic [63:0]   wd[4];
  logic [7:0]    wb[4];
  logic          wf[4];
  int            nwr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int vi);
    vec_t cur;
    int sent, cyc, we_bad;
    bit v, comp;
    cur = vec[vi];
    start = 1'b1; pix_valid = 1'b0; pix_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("v%0d ready_after_start", vi), 64'(pix_ready), 64'd1);
    chk($sformatf("v%0d err_cleared", vi), 64'(err), 64'd0);
    sent = 0; cyc = 0; we_bad = 0; nwr = 0;
    while (sent < cur.n && cyc < 200) begin
      v = cur.gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_valid = v;
      pix_data  = 8'(sent + 1);
      pix_last  = cur.use_last && (sent == cur.n - 1);
      @(posedge clk); #1;
      comp = 1'b0;
      if (v) begin
        comp = (sent % 8 == 7) || (sent == cur.n - 1);
        sent++;
      end
      if (ram_we !== comp) we_bad++;
      if (ram_we === 1'b1) begin
        if (nwr < 4) begin
          wa[nwr] = ram_addr; wd[nwr] = ram_data; wb[nwr] = ram_be; wf[nwr] = frame_done;
        end
        nwr++;
      end
      cyc++;
    end
    pix_valid = 1'b0; pix_last = 1'b0;
    chk($sformatf("v%0d pixels_sent", vi), 64'(sent), 64'(cur.n));
    chk($sformatf("v%0d we_timing_errors", vi), 64'(we_bad), 64'd0);
    chk($sformatf("v%0d write_count", vi), 64'(nwr), 64'(cur.nw));
    for (int i = 0; i < cur.nw && i < 4; i++) begin
      chk($sformatf("v%0d w%0d addr", vi, i), 64'(wa[i]), (i == 0) ? 64'(cur.a0) : 64'(cur.a1));
      chk($sformatf("v%0d w%0d data", vi, i), wd[i], (i == 0) ? cur.d0 : cur.d1);
      chk($sformatf("v%0d w%0d be", vi, i), 64'(wb[i]), (i == 0) ? 64'(cur.b0) : 64'(cur.b1));
      chk($sformatf("v%0d w%0d frame_done", vi, i), 64'(wf[i]), 64'(i == cur.nw - 1));
    end
    chk($sformatf("v%0d err", vi), 64'(err), 64'(cur.exp_err));
    chk($sformatf("v%0d ready_after_final", vi), 64'(pix_ready), 64'd0);
  endtask

  initial begin
    int we_cnt, rdy_cnt;

    vec[0] = '{16, 1'b1, 1'b0, 2, 0, 64'h0807060504030201, 8'hFF, 1, 64'h100F0E0D0C0B0A09, 8'hFF, 1'b0};
    vec[1] = '{12, 1'b1, 1'b0, 2, 0, 64'h0807060504030201, 8'hFF, 1, 64'h000000000C0B0A09, 8'h0F, 1'b1};
    vec[2] = '{16, 1'b1, 1'b1, 2, 0, 64'h0807060504030201, 8'hFF, 1, 64'h100F0E0D0C0B0A09, 8'hFF, 1'b0};
    vec[3] = '{16, 1'b0, 1'b0, 2, 0, 64'h0807060504030201, 8'hFF, 1, 64'h100F0E0D0C0B0A09, 8'hFF, 1'b1};
    vec[4] = '{5,  1'b1, 1'b0, 1, 0, 64'h0000000504030201, 8'h1F, 0, 64'h0, 8'h00, 1'b1};
    vec[5] = '{8,  1'b1, 1'b0, 1, 0, 64'h0807060504030201, 8'hFF, 0, 64'h0, 8'h00, 1'b1};
    vec[6] = '{9,  1'b1, 1'b1, 2, 0, 64'h0807060504030201, 8'hFF, 1, 64'h0000000000000009, 8'h01, 1'b1};
    vec[7] = '{16, 1'b1, 1'b0, 2, 0, 64'h0807060504030201, 8'hFF, 1, 64'h100F0E0D0C0B0A09, 8'hFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; pix_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {ram_data}, 64'h0);
    chk("reset ctrl", {44'h0, ram_addr, ram_be, ram_we, frame_done, err, pix_ready}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pixels offered with no start must be ignored.
    we_cnt = 0; rdy_cnt = 0;
    pix_valid = 1'b1; pix_data = 8'hAA;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ram_we === 1'b1) we_cnt++;
      if (pix_ready !== 1'b0) rdy_cnt++;
    end
    pix_valid = 1'b0;
    chk("idle ram_we count", 64'(we_cnt), 64'd0);
    chk("idle pix_ready count", 64'(rdy_cnt), 64'd0);

    // Reset in the middle of a frame discards the partial word.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; pix_data = 8'(8'hC0 + i); pix_last = 1'b0;
      @(posedge clk); #1;
      if (ram_we === 1'b1) we_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset writes before reset", 64'(we_cnt), 64'd0);
    chk("midreset outputs", {44'h0, ram_addr, ram_be, ram_we, frame_done, err, pix_ready}, 64'h0);
    we_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ram_we === 1'b1) we_cnt++;
    end
    chk("midreset writes during reset", 64'(we_cnt), 64'd0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frames run back to back: each start lands in the previous frame_done cycle.
    for (int vi = 0; vi < 8; vi++) run_frame(vi);

    repeat (3) @(posedge clk);
    #1;
    chk("hold addr", 64'(ram_addr), 64'd1);
    chk("hold data", ram_data, 64'h100F0E0D0C0B0A09);
    chk("hold be_we_done", {58'h0, ram_be, ram_we, frame_done} >> 0, {58'h0, 8'hFF, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
